// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//
// Shows the 32-bit value from the CPU display syscall path as hex digits on a
// time-multiplexed, common-anode seven-segment array. Captured values are
// held in a shadow register and copied to the scanned value only at frame
// boundaries, so one scan frame never mixes digits from two values. The
// decimal point of digit 0 mirrors the CPU halt level. A saturating counter
// records how many display updates were accepted.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   disp_we       display syscall strobe (one cycle per syscall)
//   disp_data     value to display, sampled when disp_we=1
//   halt          CPU halted level
//   seg_n         active-low segments, bit0=a .. bit6=g (registered)
//   dp_n          active-low decimal point (registered)
//   an_n          active-low digit enables, one low outside reset (registered)
//   shown_value   value currently being scanned
//   update_count  saturating count of accepted disp_we pulses
// -----------------------------------------------------------------------------
module seg_display_scanner #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_we,
  input  logic [31:0]       disp_data,
  input  logic              halt,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic [DIGITS-1:0] an_n,
  output logic [31:0]       shown_value,
  output logic [CNT_W-1:0]  update_count
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // Hex digit to active-low segment pattern (bit0=a .. bit6=g).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  // State registers
  logic [PW-1:0]     presc_q,   presc_d;
  logic [IW-1:0]     idx_q,     idx_d;
  logic [31:0]       active_q,  active_d;
  logic [31:0]       shadow_q,  shadow_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [6:0]        seg_q,     seg_d;
  logic              dp_q,      dp_d;
  logic [DIGITS-1:0] an_q,      an_d;

  logic tick;
  logic frame_end;
  logic nz_at_or_above;   // some nibble at idx_d or higher is nonzero

  assign tick      = (presc_q == PRESC_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (disp_we) begin
      shadow_d  = disp_data;
      pending_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A strobe landing on the frame_end edge bypasses the shadow so the
    // newest value is never left waiting a whole extra frame.
    if (frame_end) begin
      pending_d = 1'b0;
      if (disp_we) begin
        active_d = disp_data;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
    end
  end

  // Leading-zero blanking looks at the value that will be on display after
  // this edge, so the registered outputs match the scanned value exactly.
  always_comb begin
    nz_at_or_above = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(idx_d)) && (active_d[4*i +: 4] != 4'h0)) begin
        nz_at_or_above = 1'b1;
      end
    end
  end

  always_comb begin
    an_d = ~(DIGITS'(1) << idx_d);
    dp_d = !((idx_d == '0) && halt);
    if ((idx_d != '0) && !nz_at_or_above) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = hex_to_seg(active_d[{idx_d, 2'b00} +: 4]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= '1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg_n        = seg_q;
  assign dp_n         = dp_q;
  assign an_n         = an_q;
  assign shown_value  = active_q;
  assign update_count = cnt_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scanner
//
// Drives directed display strobes into two scanners (default counter width
// and a 4-bit counter build) and compares every cycle against a behavioural
// model that derives digit position from elapsed cycles since reset release.
// Literal expectations at hand-picked points pin the model itself.
// -----------------------------------------------------------------------------
module tb_seg_display_scanner;

  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              disp_we = 1'b0;
  logic [31:0]       disp_data = '0;
  logic              halt = 1'b0;

  logic [6:0]        seg_n;
  logic              dp_n;
  logic [DIGITS-1:0] an_n;
  logic [31:0]       shown_value;
  logic [15:0]       update_count;

  logic [6:0]        seg_n4;
  logic              dp_n4;
  logic [DIGITS-1:0] an_n4;
  logic [31:0]       shown_value4;
  logic [3:0]        update_count4;

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  seg_display_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .disp_we      (disp_we),
    .disp_data    (disp_data),
    .halt         (halt),
    .seg_n        (seg_n),
    .dp_n         (dp_n),
    .an_n         (an_n),
    .shown_value  (shown_value),
    .update_count (update_count)
  );

  seg_display_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .CNT_W(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .disp_we      (disp_we),
    .disp_data    (disp_data),
    .halt         (halt),
    .seg_n        (seg_n4),
    .dp_n         (dp_n4),
    .an_n         (an_n4),
    .shown_value  (shown_value4),
    .update_count (update_count4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_n;          // rising edges since reset release
  logic [31:0] m_active;
  logic [31:0] m_shadow;
  logic        m_pend;
  int          m_cnt;
  logic [6:0]        exp_seg;
  logic              exp_dp;
  logic [DIGITS-1:0] exp_an;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n      <= 0;
      m_active <= '0;
      m_shadow <= '0;
      m_pend   <= 1'b0;
      m_cnt    <= 0;
      exp_seg  <= 7'h7F;
      exp_dp   <= 1'b1;
      exp_an   <= '1;
    end else begin : model_step
      logic [31:0] a_nx;
      logic [31:0] upper;
      int          d;
      bit          fe;
      fe   = ((m_n + 1) % FRAME) == 0;
      d    = ((m_n + 1) / SCAN_DIV) % DIGITS;
      a_nx = m_active;
      if (fe) begin
        if (disp_we)     a_nx = disp_data;
        else if (m_pend) a_nx = m_shadow;
      end
      upper = a_nx >> (4 * d);
      exp_seg  <= (d > 0 && upper == 0) ? 7'h7F : HEX[upper[3:0]];
      exp_an   <= ~(DIGITS'(1) << d);
      exp_dp   <= !(d == 0 && halt);
      m_active <= a_nx;
      m_pend   <= fe ? 1'b0 : (m_pend || disp_we);
      if (disp_we) begin
        m_shadow <= disp_data;
        m_cnt    <= m_cnt + 1;
      end
      m_n <= m_n + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("seg_n", 64'(seg_n), 64'(exp_seg));
      check("an_n", 64'(an_n), 64'(exp_an));
      check("dp_n", 64'(dp_n), 64'(exp_dp));
      check("shown_value", 64'(shown_value), 64'(m_active));
      check("update_count", 64'(update_count), 64'((m_cnt > 16'hFFFF) ? 16'hFFFF : m_cnt));
      check("update_count4", 64'(update_count4), 64'((m_cnt > 15) ? 15 : m_cnt));
      check("shown_value4", 64'(shown_value4), 64'(m_active));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench just after a negedge, before rising edge 0.
  task automatic do_reset();
    disp_we   = 1'b0;
    disp_data = '0;
    halt      = 1'b0;
    rst_n     = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic strobe(input logic [31:0] v);
    disp_we   = 1'b1;
    disp_data = v;
    step(1);
    disp_we   = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(1);
    cmp_en = 1'b1;

    // Idle scan after reset
    do_reset();
    check("rst seg_n", 64'(seg_n), 64'h7F);
    check("rst an_n", 64'(an_n), 64'hFF);
    step(1);                                   // after edge 0
    check("idle d0 an_n", 64'(an_n), 64'hFE);
    check("idle d0 seg_n", 64'(seg_n), 64'h40);
    step(3);                                   // after edge 3
    check("idle d1 an_n", 64'(an_n), 64'hFD);
    check("idle d1 seg_n", 64'(seg_n), 64'h7F);
    step(36);

    // Single strobe mid-frame, committed at frame end
    do_reset();
    step(5);
    strobe(32'h0000_00A5);                     // edge 5
    step(25);                                  // after edge 30
    check("A5 before commit", 64'(shown_value), 64'h0);
    step(1);                                   // after edge 31
    check("A5 committed", 64'(shown_value), 64'hA5);
    check("A5 digit0 seg", 64'(seg_n), 64'h12);
    step(4);
    check("A5 digit1 seg", 64'(seg_n), 64'h08);
    step(4);
    check("A5 digit2 seg", 64'(seg_n), 64'h7F);

    // Back-to-back strobes, last one wins
    do_reset();
    step(3);
    strobe(32'h1234_5678);                     // edge 3
    strobe(32'hDEAD_BEEF);                     // edge 4
    step(27);                                  // after edge 31
    check("b2b shown", 64'(shown_value), 64'hDEAD_BEEF);
    check("b2b count", 64'(update_count), 64'd2);
    check("b2b digit0 seg", 64'(seg_n), 64'h0E);
    step(28);                                  // after edge 59
    check("b2b digit7 an", 64'(an_n), 64'h7F);
    check("b2b digit7 seg", 64'(seg_n), 64'h21);

    // Strobe on the frame_end cycle bypasses the shadow
    do_reset();
    step(31);
    strobe(32'h8000_0000);                     // edge 31
    check("bypass shown", 64'(shown_value), 64'h8000_0000);
    check("bypass digit0 seg", 64'(seg_n), 64'h40);
    step(4);
    check("bypass digit1 seg", 64'(seg_n), 64'h40);
    step(24);                                  // after edge 59
    check("bypass digit7 seg", 64'(seg_n), 64'h00);

    // Halt drives the digit-0 decimal point only
    halt = 1'b1;
    step(1);                                   // after edge 60, digit 7
    check("halt dp off digit7", 64'(dp_n), 64'h1);
    step(3);                                   // after edge 63, digit 0
    check("halt an digit0", 64'(an_n), 64'hFE);
    check("halt dp digit0", 64'(dp_n), 64'h0);
    halt = 1'b0;
    step(1);
    check("halt released dp", 64'(dp_n), 64'h1);
    halt = 1'b1;
    step(40);
    halt = 1'b0;

    // Reset mid-frame with a pending value
    strobe(32'h0000_0777);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check("async rst seg_n", 64'(seg_n), 64'h7F);
    check("async rst an_n", 64'(an_n), 64'hFF);
    check("async rst dp_n", 64'(dp_n), 64'h1);
    check("async rst count", 64'(update_count), 64'h0);
    step(2);
    rst_n = 1'b1;
    step(70);
    check("discarded shadow", 64'(shown_value), 64'h0);

    // Counter saturation on the 4-bit build
    do_reset();
    step(2);
    for (int i = 0; i < 20; i++) begin
      disp_we   = 1'b1;
      disp_data = 32'h100 + 32'(i);
      step(1);
    end
    disp_we = 1'b0;
    check("sat count16", 64'(update_count), 64'd20);
    check("sat count4", 64'(update_count4), 64'hF);
    step(40);
    check("sat last value", 64'(shown_value), 64'h113);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
